// File: rtl/mem_model_mp_if.sv
// Request/return bus for the multi-port line memory model.
// Each per-port field is packed, port p occupying slice [p*W +: W].
interface mem_model_mp_if #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_W    = 128,
    parameter int ADDR_W    = 32
) ();
    logic [NUM_PORTS-1:0]        rden;
    logic [NUM_PORTS-1:0]        wren;
    logic [NUM_PORTS*ADDR_W-1:0] addr_in;
    logic [NUM_PORTS*LINE_W-1:0] data_in;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS*LINE_W-1:0] data_out;
    logic [NUM_PORTS-1:0]        data_out_valid;

    modport master (
        output rden, wren, addr_in, data_in,
        input  req_ready, data_out, data_out_valid
    );

    modport slave (
        input  rden, wren, addr_in, data_in,
        output req_ready, data_out, data_out_valid
    );
endinterface

// File: rtl/mem_model_mp.sv
// Multi-port line-granular memory model.
// Each port has a one-entry hold register; one held request is granted per
// cycle in round-robin order. Writes commit at the grant edge, reads return
// through a fixed-latency pipeline LATENCY cycles after their grant.
// Optional build macro: MEM_MODEL_GARBAGE_FILL_EN -- reads of lines not
// written since reset return a pseudo-random garbage pattern instead of
// the store contents.
module mem_model_mp #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_W    = 128,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 5
) (
    input  logic          clk,
    input  logic          reset,
    mem_model_mp_if.slave bus
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NUM_PORTS-1:0] hold_vld;
    logic [NUM_PORTS-1:0] hold_wr;
    logic [IDX_W-1:0]     hold_line [NUM_PORTS];
    logic [LINE_W-1:0]    hold_data [NUM_PORTS];

    logic                 gnt_vld;
    logic [PTR_W-1:0]     gnt_port;
    logic [NUM_PORTS-1:0] gnt_oh;
    logic                 gnt_wr;
    logic [IDX_W-1:0]     gnt_line;
    logic [LINE_W-1:0]    gnt_data;
    logic [PTR_W-1:0]     rr_start;
    logic [PTR_W-1:0]     rr_next;
    logic [LINE_W-1:0]    rd_line;

    logic [LINE_W-1:0]    store [DEPTH];

    logic [NUM_PORTS-1:0] pipe_oh   [LATENCY];
    logic [LINE_W-1:0]    pipe_data [LATENCY];
    logic [LINE_W-1:0]    last_data [NUM_PORTS];

    // Only the line-index field of the byte address selects a line; the
    // byte offset and the upper bits are deliberately dropped (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr_in;

    // Round-robin pick: scan from rr_start; lowest offset wins, so the scan
    // runs backwards and the last hit is kept.
    always_comb begin
        int idx;
        idx      = 0;
        gnt_vld  = 1'b0;
        gnt_port = '0;
        gnt_oh   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = (int'(rr_start) + i) % NUM_PORTS;
            if (hold_vld[idx]) begin
                gnt_vld  = 1'b1;
                gnt_port = PTR_W'(idx);
            end
        end
        if (gnt_vld) begin
            gnt_oh[gnt_port] = 1'b1;
        end
        rr_next  = PTR_W'((int'(gnt_port) + 1) % NUM_PORTS);
        gnt_wr   = hold_wr[gnt_port];
        gnt_line = hold_line[gnt_port];
        gnt_data = hold_data[gnt_port];
    end

    // Hold registers: capture on accept, free at grant. A held port cannot
    // accept, so the two never collide on the same port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_vld <= '0;
            hold_wr  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                hold_line[p] <= '0;
                hold_data[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt_oh[p]) begin
                    hold_vld[p] <= 1'b0;
                end else if (!hold_vld[p] && (bus.rden[p] || bus.wren[p])) begin
                    hold_vld[p]  <= 1'b1;
                    hold_wr[p]   <= bus.wren[p];
                    hold_line[p] <= bus.addr_in[p*ADDR_W + OFF_W +: IDX_W];
                    hold_data[p] <= bus.data_in[p*LINE_W +: LINE_W];
                end
            end
        end
    end

    // Round-robin pointer: next search starts after the last granted port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_start <= '0;
        end else if (gnt_vld) begin
            rr_start <= rr_next;
        end
    end

    // Backing store: not reset, so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (gnt_vld && gnt_wr) begin
            store[gnt_line] <= gnt_data;
        end
    end

`ifdef MEM_MODEL_GARBAGE_FILL_EN
    localparam logic [LINE_W-1:0] GARBAGE_SEED =
        LINE_W'(128'hFB63DA9647CC13DC9913FA22DEADBEEF);

    logic [DEPTH-1:0]  written_q;
    logic [LINE_W-1:0] garbage_q;
    logic [LINE_W-1:0] garbage_next;

    // Next garbage word: seed XOR previous garbage rotated left by one.
    always_comb begin
        garbage_next = GARBAGE_SEED ^ {garbage_q[LINE_W-2:0], garbage_q[LINE_W-1]};
    end

    // Written flags and the shared garbage generator; the generator only
    // steps when an unwritten line is actually read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            written_q <= '0;
            garbage_q <= '0;
        end else if (gnt_vld) begin
            if (gnt_wr) begin
                written_q[gnt_line] <= 1'b1;
            end else if (!written_q[gnt_line]) begin
                garbage_q <= garbage_next;
            end
        end
    end

    // Read data: store contents for written lines, garbage otherwise.
    always_comb begin
        rd_line = written_q[gnt_line] ? store[gnt_line] : garbage_next;
    end
`else
    // Read data straight from the store.
    always_comb begin
        rd_line = store[gnt_line];
    end
`endif

    // Return pipeline: one-hot port tag plus data, one stage per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_oh[k]   <= '0;
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_oh[0]   <= (gnt_vld && !gnt_wr) ? gnt_oh : '0;
            pipe_data[0] <= rd_line;
            for (int k = 1; k < LATENCY; k++) begin
                pipe_oh[k]   <= pipe_oh[k-1];
                pipe_data[k] <= pipe_data[k-1];
            end
        end
    end

    // Per-port copy of the last returned line, shown while valid is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                last_data[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (pipe_oh[LATENCY-1][p]) begin
                    last_data[p] <= pipe_data[LATENCY-1];
                end
            end
        end
    end

    // Bus outputs.
    always_comb begin
        bus.req_ready      = ~hold_vld;
        bus.data_out_valid = pipe_oh[LATENCY-1];
        bus.data_out       = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.data_out[p*LINE_W +: LINE_W] =
                pipe_oh[LATENCY-1][p] ? pipe_data[LATENCY-1] : last_data[p];
        end
    end
endmodule
